// File: rtl/vga_rx_pkg.sv
// Shared definitions for the VGA receive monitor: default timing,
// coordinate/colour widths, FSM state type and a saturating counter helper.
package vga_rx_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 24;

  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_TOTAL     = 525;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_LOCK_FRAMES = 2;
  localparam int DEF_WDOG_CYCLES = 16;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/vga_edge_sampler.sv
// Front end of the VGA monitor: registers every input once, turns the
// sampled pixel clock into a one-clk strobe and detects sync/blank edges
// between consecutive strobes.
module vga_edge_sampler
  import vga_rx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               vga_clk,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank_n,
  input  logic [RGB_W-1:0]   pix_rgb,
  input  logic [COORD_W-1:0] probe_x,
  input  logic [COORD_W-1:0] probe_y,
  output logic               stb,
  output logic               hfall,
  output logic               vfall,
  output logic               blank_rise,
  output logic               blank_q,
  output logic [RGB_W-1:0]   rgb_q,
  output logic [COORD_W-1:0] probe_x_q,
  output logic [COORD_W-1:0] probe_y_q
);

  logic vga_clk_q;
  logic vga_clk_d;
  logic hsync_q;
  logic vsync_q;
  logic hsync_seen;
  logic vsync_seen;
  logic blank_seen;

  // Single register stage on every input; syncs idle high so reset never fakes a falling edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      vga_clk_q <= 1'b0;
      vga_clk_d <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_q   <= 1'b0;
      rgb_q     <= '0;
      probe_x_q <= '0;
      probe_y_q <= '0;
    end else begin
      vga_clk_q <= vga_clk;
      vga_clk_d <= vga_clk_q;
      hsync_q   <= hsync;
      vsync_q   <= vsync;
      blank_q   <= blank_n;
      rgb_q     <= pix_rgb;
      probe_x_q <= probe_x;
      probe_y_q <= probe_y;
    end
  end

  assign stb = vga_clk_q & ~vga_clk_d;

  // Levels seen at the previous pixel strobe, so edges are judged pixel to pixel
  always_ff @(posedge clk) begin
    if (!rst) begin
      hsync_seen <= 1'b1;
      vsync_seen <= 1'b1;
      blank_seen <= 1'b0;
    end else if (stb) begin
      hsync_seen <= hsync_q;
      vsync_seen <= vsync_q;
      blank_seen <= blank_q;
    end
  end

  assign hfall      = stb & hsync_seen & ~hsync_q;
  assign vfall      = stb & vsync_seen & ~vsync_q;
  assign blank_rise = stb & ~blank_seen & blank_q;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel coordinates from sync/blank, measures
// line and frame timing, tracks timing lock and samples the colour at a
// programmable probe coordinate once per frame.
module vga_rx_monitor
  import vga_rx_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               vga_clk,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               blank_n,
  input  logic [RGB_W-1:0]   pix_rgb,
  input  logic [COORD_W-1:0] probe_x,
  input  logic [COORD_W-1:0] probe_y,
  output logic [COORD_W-1:0] rx_x,
  output logic [COORD_W-1:0] rx_y,
  output logic               locked,
  output logic               frame_done,
  output logic [RGB_W-1:0]   probe_color,
  output logic               probe_valid,
  output logic [COORD_W-1:0] line_len,
  output logic [COORD_W-1:0] frame_lines,
  output logic [7:0]         err_count
);

  localparam logic [COORD_W-1:0] H_TOTAL_C  = COORD_W'(H_TOTAL);
  localparam logic [COORD_W-1:0] H_ACTIVE_C = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_TOTAL_C  = COORD_W'(V_TOTAL);
  localparam logic [COORD_W-1:0] V_ACTIVE_C = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] ONE_C      = COORD_W'(1);
  localparam logic [7:0]         LOCK_LAST  = 8'(LOCK_FRAMES - 1);
  localparam int                 WDOG_W     = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WDOG_W-1:0]  WDOG_MAX   = WDOG_W'(WDOG_CYCLES);

  logic               stb;
  logic               hfall;
  logic               vfall;
  logic               blank_rise;
  logic               blank_q;
  logic [RGB_W-1:0]   rgb_q;
  logic [COORD_W-1:0] probe_x_q;
  logic [COORD_W-1:0] probe_y_q;

  vga_edge_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .vga_clk    (vga_clk),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank_n    (blank_n),
    .pix_rgb    (pix_rgb),
    .probe_x    (probe_x),
    .probe_y    (probe_y),
    .stb        (stb),
    .hfall      (hfall),
    .vfall      (vfall),
    .blank_rise (blank_rise),
    .blank_q    (blank_q),
    .rgb_q      (rgb_q),
    .probe_x_q  (probe_x_q),
    .probe_y_q  (probe_y_q)
  );

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [COORD_W-1:0] act_cnt;
  logic [COORD_W-1:0] act_lines;
  logic [COORD_W-1:0] shadow_x;
  logic [COORD_W-1:0] shadow_y;
  logic [WDOG_W-1:0]  wdog;
  logic [7:0]         good;
  logic               first_h;
  logic               skip_v;
  rx_state_e          state;

  // Values as they stand once the current strobe is included; a line ending on
  // the same strobe as a frame is counted before the frame is judged.
  logic [COORD_W-1:0] h_next;
  logic [COORD_W-1:0] act_next;
  logic [COORD_W-1:0] v_next;
  logic [COORD_W-1:0] lines_next;
  logic               line_err;
  logic               act_err;
  logic               frame_err;
  logic               wdog_hit;
  logic               any_err;
  logic               probe_hit;

  assign h_next     = h_cnt + ONE_C;
  assign act_next   = act_cnt + {{(COORD_W-1){1'b0}}, blank_q};
  assign v_next     = v_cnt + {{(COORD_W-1){1'b0}}, hfall};
  assign lines_next = act_lines + {{(COORD_W-1){1'b0}}, (hfall && act_next == H_ACTIVE_C)};

  assign line_err  = hfall && !first_h && (h_next != H_TOTAL_C);
  assign act_err   = hfall && (act_next != '0) && (act_next != H_ACTIVE_C);
  assign frame_err = vfall && !skip_v && ((v_next != V_TOTAL_C) || (lines_next != V_ACTIVE_C));
  assign wdog_hit  = (state != SEARCH) && !stb && (wdog == WDOG_LAST);
  assign any_err   = (state != SEARCH) && (line_err || act_err || frame_err || wdog_hit);

  assign probe_hit = (state == LOCKED) && stb && blank_q &&
                     (act_cnt == shadow_x) && (act_lines == shadow_y) &&
                     (shadow_x < H_ACTIVE_C) && (shadow_y < V_ACTIVE_C);

  // Pixel, line and frame counters plus the measured timing and recovered coordinates
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      act_cnt     <= '0;
      act_lines   <= '0;
      shadow_x    <= '0;
      shadow_y    <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      rx_x        <= '0;
      rx_y        <= '0;
    end else if (stb) begin
      if (hfall) begin
        h_cnt    <= '0;
        act_cnt  <= '0;
        line_len <= h_next;
      end else begin
        h_cnt   <= h_next;
        act_cnt <= act_next;
      end
      if (vfall) begin
        v_cnt       <= '0;
        act_lines   <= '0;
        frame_lines <= v_next;
        shadow_x    <= probe_x_q;
        shadow_y    <= probe_y_q;
      end else begin
        v_cnt     <= v_next;
        act_lines <= lines_next;
      end
      if (blank_q) begin
        rx_x <= act_cnt;
      end
      if (blank_rise) begin
        rx_y <= act_lines;
      end
    end
  end

  // Colour capture at the probe coordinate, only trusted while timing is locked
  always_ff @(posedge clk) begin
    if (!rst) begin
      probe_color <= '0;
      probe_valid <= 1'b0;
    end else begin
      probe_valid <= probe_hit;
      if (probe_hit) begin
        probe_color <= rgb_q;
      end
    end
  end

  // Loss-of-signal timer: clk cycles since the last pixel strobe, parked while searching
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog <= '0;
    end else if (state == SEARCH || stb) begin
      wdog <= '0;
    end else if (wdog != WDOG_MAX) begin
      wdog <= wdog + WDOG_W'(1);
    end
  end

  // Lock state machine with registered lock flag, frame pulse and error counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= SEARCH;
      good       <= '0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      err_count  <= '0;
      first_h    <= 1'b0;
      skip_v     <= 1'b0;
    end else begin
      frame_done <= vfall && (state != SEARCH);
      if (any_err) begin
        err_count <= sat_inc8(err_count);
      end
      if (hfall) begin
        first_h <= 1'b0;
      end
      if (vfall) begin
        skip_v <= 1'b0;
      end
      case (state)
        SEARCH: begin
          if (vfall) begin
            state   <= TRAIN;
            good    <= '0;
            first_h <= 1'b1;
            skip_v  <= 1'b1;
          end
        end
        TRAIN: begin
          if (any_err) begin
            good <= '0;
            if (wdog_hit) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end
          end else if (vfall) begin
            good <= good + 8'd1;
            if (good == LOCK_LAST) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (any_err) begin
            state  <= SEARCH;
            locked <= 1'b0;
            good   <= '0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor with a 10x8 pixel mode: a frame table drives
// clean and corrupted frames while queued expectations are matched against
// frame_done and probe_valid pulses.
module tb_vga_rx_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        vga_clk;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [23:0] pix_rgb;
  logic [9:0]  probe_x;
  logic [9:0]  probe_y;
  logic [9:0]  rx_x;
  logic [9:0]  rx_y;
  logic        locked;
  logic        frame_done;
  logic [23:0] probe_color;
  logic        probe_valid;
  logic [9:0]  line_len;
  logic [9:0]  frame_lines;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         long_line;
    int         short_line;
    int         stall_line;
    logic [9:0] px;
    logic [9:0] py;
    bit         exp_fd;
    bit         exp_probe;
    bit         exp_locked;
    int         exp_err;
  } frame_vec_t;

  typedef struct {
    logic       lk;
    logic [7:0] err;
    logic [9:0] ll;
    logic [9:0] fl;
  } fd_exp_t;

  typedef struct {
    logic [23:0] color;
    logic [9:0]  x;
    logic [9:0]  y;
  } probe_exp_t;

  fd_exp_t    fd_q[$];
  probe_exp_t probe_q[$];
  frame_vec_t tbl[14];

  vga_rx_monitor #(
    .H_TOTAL     (10),
    .H_ACTIVE    (6),
    .V_TOTAL     (8),
    .V_ACTIVE    (5),
    .LOCK_FRAMES (2),
    .WDOG_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_clk     (vga_clk),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .pix_rgb     (pix_rgb),
    .probe_x     (probe_x),
    .probe_y     (probe_y),
    .rx_x        (rx_x),
    .rx_y        (rx_y),
    .locked      (locked),
    .frame_done  (frame_done),
    .probe_color (probe_color),
    .probe_valid (probe_valid),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic frame_vec_t mk(input int ll, input int sl, input int st,
                                    input int px, input int py, input bit fd,
                                    input bit pr, input bit lk, input int er);
    frame_vec_t v;
    v.long_line  = ll;
    v.short_line = sl;
    v.stall_line = st;
    v.px         = 10'(px);
    v.py         = 10'(py);
    v.exp_fd     = fd;
    v.exp_probe  = pr;
    v.exp_locked = lk;
    v.exp_err    = er;
    return v;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rx_x"}, 32'(rx_x), 0);
    checkOutput({tag, "_rx_y"}, 32'(rx_y), 0);
    checkOutput({tag, "_locked"}, 32'(locked), 0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 0);
    checkOutput({tag, "_probe_color"}, 32'(probe_color), 0);
    checkOutput({tag, "_probe_valid"}, 32'(probe_valid), 0);
    checkOutput({tag, "_line_len"}, 32'(line_len), 0);
    checkOutput({tag, "_frame_lines"}, 32'(frame_lines), 0);
    checkOutput({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  // Drives n_lines of a frame, two clk per pixel; vsync low for line 6, hsync low at pixels 7-8
  task automatic applyStimulus(input frame_vec_t row, input int n_lines);
    probe_x = row.px;
    probe_y = row.py;
    for (int ln = 0; ln < n_lines; ln++) begin
      int len;
      len = (ln == row.long_line) ? 11 : 10;
      if (ln == row.stall_line) begin
        repeat (20) @(negedge clk);
        checkOutput("wdog_locked", 32'(locked), 0);
        checkOutput("wdog_err_count", 32'(err_count), 32'(row.exp_err));
      end
      for (int px = 0; px < len; px++) begin
        @(negedge clk);
        vga_clk = 1'b1;
        hsync   = !(px == 7 || px == 8);
        vsync   = (ln != 6);
        blank_n = (ln < 5) && (px < 6) && !(ln == row.short_line && px >= 4);
        pix_rgb = (ln == 2 && px == 3) ? 24'h00FF00 : 24'h000000;
        if (ln == 6 && px == 0 && row.exp_fd)
          fd_q.push_back('{lk: row.exp_locked, err: 8'(row.exp_err), ll: 10'd10, fl: 10'd8});
        if (ln == 2 && px == 3 && row.exp_probe)
          probe_q.push_back('{color: 24'h00FF00, x: 10'd3, y: 10'd2});
        @(negedge clk);
        vga_clk = 1'b0;
      end
    end
  endtask

  // Output-side scoreboard: each pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (frame_done) begin
      if (fd_q.size() == 0) begin
        checkOutput("frame_done_unexpected", 32'(frame_done), 0);
      end else begin
        fd_exp_t e;
        e = fd_q.pop_front();
        checkOutput("fd_locked", 32'(locked), 32'(e.lk));
        checkOutput("fd_err_count", 32'(err_count), 32'(e.err));
        checkOutput("fd_line_len", 32'(line_len), 32'(e.ll));
        checkOutput("fd_frame_lines", 32'(frame_lines), 32'(e.fl));
      end
    end
    if (probe_valid) begin
      if (probe_q.size() == 0) begin
        checkOutput("probe_valid_unexpected", 32'(probe_valid), 0);
      end else begin
        probe_exp_t p;
        p = probe_q.pop_front();
        checkOutput("probe_color", 32'(probe_color), 32'(p.color));
        checkOutput("probe_rx_x", 32'(rx_x), 32'(p.x));
        checkOutput("probe_rx_y", 32'(rx_y), 32'(p.y));
      end
    end
  end

  initial begin
    frame_vec_t pre;
    tbl[0]  = mk(-1, -1, -1, 3, 2, 0, 0, 0, 0);
    tbl[1]  = mk(-1, -1, -1, 3, 2, 1, 0, 0, 0);
    tbl[2]  = mk(-1, -1, -1, 3, 2, 1, 0, 1, 0);
    tbl[3]  = mk(-1, -1, -1, 6, 0, 1, 1, 1, 0);
    tbl[4]  = mk(-1, -1, -1, 3, 2, 1, 0, 1, 0);
    tbl[5]  = mk( 3, -1, -1, 3, 2, 0, 1, 0, 1);
    tbl[6]  = mk(-1, -1, -1, 3, 2, 1, 0, 0, 1);
    tbl[7]  = mk(-1, -1, -1, 3, 2, 1, 0, 1, 1);
    tbl[8]  = mk(-1, -1,  3, 3, 2, 0, 1, 0, 2);
    tbl[9]  = mk(-1, -1, -1, 3, 2, 1, 0, 0, 2);
    tbl[10] = mk(-1,  1, -1, 3, 2, 1, 0, 0, 4);
    tbl[11] = mk(-1, -1, -1, 3, 2, 1, 0, 0, 4);
    tbl[12] = mk(-1, -1, -1, 3, 2, 1, 0, 1, 4);
    tbl[13] = mk(-1, -1, -1, 3, 2, 1, 1, 1, 4);
    pre     = mk(-1, -1, -1, 3, 2, 0, 0, 0, 0);

    rst     = 1'b0;
    vga_clk = 1'b0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    blank_n = 1'b0;
    pix_rgb = '0;
    probe_x = 10'd3;
    probe_y = 10'd2;
    repeat (4) @(negedge clk);
    checkResetState("por");
    rst = 1'b1;

    $display("[TB] one frame plus three lines, then reset mid-frame");
    applyStimulus(pre, 8);
    applyStimulus(pre, 3);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("midrst");
    rst = 1'b1;

    $display("[TB] frame table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i], 8);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("f%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
      checkOutput($sformatf("f%0d_err_count", i), 32'(err_count), 32'(tbl[i].exp_err));
      checkOutput($sformatf("f%0d_fd_pending", i), 32'(fd_q.size()), 0);
      checkOutput($sformatf("f%0d_probe_pending", i), 32'(probe_q.size()), 0);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receiving end of the VGA interface.
- Samples the VGA pixel clock, sync, blank and 24-bit colour exactly as driven to the DAC. It recovers the pixel coordinates and checks line and frame timing against parameters.
- It also captures the colour at a probe coordinate once per frame.
- Sits beside the game top-level on clk. It is used in-system (colour readback, timing lock indicator) and as a self-checking monitor in benches.

Parameters:
- H_TOTAL, 800, vga_clk periods per line
- H_ACTIVE, 640, active (blank_n=1) pixels per line
- V_TOTAL, 525, lines per frame
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive clean frames needed to assert locked
- WDOG_CYCLES, 16, clk cycles without a pixel strobe before loss of signal

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-low reset
- vga_clk  in  1  pixel clock, generated from clk
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- blank_n  in  1  1 = active video
- pix_rgb  in  24  {R,G,B}
- probe_x  in  10  probe column
- probe_y  in  10  probe row
- rx_x  out  10  recovered active column
- rx_y  out  10  recovered active row
- locked  out  1  timing locked
- frame_done  out  1  one-clk pulse per checked frame
- probe_color  out  24  captured colour
- probe_valid  out  1  one-clk pulse when probe_color updates
- line_len  out  10  last measured line length
- frame_lines  out  10  last measured lines per frame
- err_count  out  8  timing errors, saturating

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, all counters 0, state SEARCH.
- Input stage: all inputs registered once. Pixel strobe stb = registered vga_clk rising (prev 0, now 1). All counting happens on stb cycles only.
- Edge detection is done on stb: hfall (hsync 1→0), vfall (vsync 1→0), blank_n rise.
- h_cnt increments each stb.
  - On hfall: line_len <= h_cnt+1, h_cnt <= 0, v_cnt++.
  - Error if line_len ≠ H_TOTAL. The first hfall after leaving SEARCH is exempt.
- act_cnt counts stb with blank_n=1 within a line; rx_x = act_cnt before increment.
  - On hfall: error if act_cnt ∉ {0, H_ACTIVE}.
  - On hfall: if act_cnt = H_ACTIVE, act_lines++. Then act_cnt cleared.
  - rx_y = act_lines.
- On vfall:
  - frame_lines <= v_cnt.
  - Error if v_cnt ≠ V_TOTAL or act_lines ≠ V_ACTIVE. Both checks are skipped on the first vfall after SEARCH.
  - v_cnt and act_lines cleared; probe_x/probe_y latched into shadow registers.
  - If hfall and vfall land on the same stb, the line is counted before the frame check.
- FSM:
  - SEARCH: wait for vfall, then go to TRAIN with good=0.
  - TRAIN: on a clean vfall, good++. When good = LOCK_FRAMES, go to LOCKED and set locked=1. Any error sets good=0 and stays in TRAIN.
  - LOCKED: any error goes to SEARCH and sets locked=0.
- err_count increments once per clk with ≥1 error while in TRAIN/LOCKED. It saturates at 255 and is not cleared by state changes.
- frame_done pulses for one clk on the clk after each vfall handled in TRAIN/LOCKED.
- Watchdog: counts clk cycles since the last stb and is cleared on stb.
  - Reaching WDOG_CYCLES in TRAIN/LOCKED goes to SEARCH, clears locked and increments err_count once.
  - In SEARCH the watchdog is idle.
- Probe: in LOCKED, on stb with blank_n=1, rx_x = shadow_x and rx_y = shadow_y: probe_color <= pix_rgb and probe_valid pulses one clk. An out-of-range probe never fires.
- Latency: an input change is reflected in outputs 2 clk after it.

Decomposition:
- Package vga_rx_pkg:
  - default timing constants (800/640/525/480)
  - FSM state enum {SEARCH, TRAIN, LOCKED}
  - width constant for 10-bit coordinates
- Sub-module vga_edge_sampler: input registers, stb generation, hfall/vfall/blank-rise detect.

Test Plan:
- The bench uses small parameters: H_TOTAL=10, H_ACTIVE=6, V_TOTAL=8, V_ACTIVE=5, LOCK_FRAMES=2, WDOG_CYCLES=16.
- Reset: hold rst=0 mid-frame for 3 clk → all outputs 0; after release, locked=0 until the first vfall.
- Clean frames: drive ideal timing for 4 frames → locked=1 after the 3rd vfall; frame_done pulses each frame; line_len=10, frame_lines=8, err_count=0.
- Probe: probe=(3,2), pixel at (3,2)=24'h00FF00, others 0 → probe_valid one pulse per frame, probe_color=24'h00FF00. probe=(6,0) → never valid.
- Bad line: locked, one line with 11 periods → err_count=1, locked=0 (SEARCH), relock 3 frames later.
- Active count: one line with 4 active pixels → err_count++; act_lines=4 → frame check error also (err_count total +2).
- Watchdog: stop vga_clk 20 clk while locked → err_count +1, locked=0; restart → relock.
